led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Controller for the four-mode LED pattern system: it owns the step-rate prescaler, decides which of the four pattern engines (modes 0–3) is active, issues one-cycle clear and step-enable strobes to that engine only, and registers the selected engine's 8-bit pattern onto the board LEDs. It sits between the user controls (mode button, auto/pause switches) and the four pattern engines, which run only when strobed by this block.

## Interface

- TICK_DIV, 4: clock cycles per pattern step; legal range ≥ 2.
- AUTO_STEPS, 16: steps spent in each mode before automatic advance; legal range ≥ 1.

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- btn_next  input  1  advance-mode request, already synchronous and debounced; acts on rising edge only
- auto_en  input  1  1 = advance mode automatically every AUTO_STEPS steps
- pause  input  1  1 = freeze stepping (prescaler and step counter hold)
- pat0, pat1, pat2, pat3  input  8 each  current pattern from engines 0–3
- mode  output  2  currently selected mode
- clr  output  4  one-hot clear strobe to the selected engine
- en  output  4  one-hot step-enable strobe to the selected engine
- led  output  8  registered copy of the selected engine's pattern

## Operation

- States: S_CLEAR, S_RUN. Reset forces state = S_CLEAR, mode = 0, prescaler = 0, step counter = 0, btn_prev = 0, led = 8'h00.
- clr = onehot(mode) while in S_CLEAR, else 4'b0000; therefore clr = 4'b0001 while reset is asserted and in the first cycle after release.
- S_CLEAR lasts exactly one cycle, then S_RUN. Prescaler and step counter are held at 0 in S_CLEAR; btn_next edges arriving in S_CLEAR are ignored (btn_prev still updates).
- Prescaler (width $clog2(TICK_DIV)) counts 0..TICK_DIV-1 in S_RUN when pause = 0, then wraps to 0. tick = S_RUN & ~pause & (prescaler == TICK_DIV-1).
- en = onehot(mode) when tick, else 4'b0000. en and clr are never both non-zero.
- Step counter counts ticks 0..AUTO_STEPS-1, wraps to 0. It keeps counting when auto_en = 0 but has no effect then.
- Advance condition (S_RUN only): btn_next rising edge (btn_next & ~btn_prev), OR (auto_en & tick & step counter == AUTO_STEPS-1). On advance: mode ← mode+1 mod 4 (3 → 0), state ← S_CLEAR, prescaler ← 0, step counter ← 0.
- Simultaneous button edge and auto expiry in one cycle: a single advance (mode +1, never +2).
- A tick coinciding with an advance still drives en to the old mode in that cycle.
- pause = 1: prescaler and step counter hold, en = 0; button advance still works; after the one-cycle S_CLEAR the block waits in S_RUN with prescaler at 0.
- led ← pat[mode] every cycle in S_RUN; led ← 8'h00 in S_CLEAR.

## Timing

- Button latency: rising edge of btn_next sampled at edge N → mode, clr updated at edge N+1 → S_RUN at N+2, first en of the new mode at N+1+TICK_DIV.
- Step period: one en pulse every TICK_DIV cycles while running, unpaused, with no advance.
- led lags the pattern input by one cycle; the engine's response to an en strobe appears on led two cycles after the strobe.
- Reset mid-operation: all state returns to reset values asynchronously in the same cycle; en drops immediately.
- Holding btn_next high produces one advance only; a new advance needs btn_next low for ≥ 1 cycle.

## Test plan

- Reset release, TICK_DIV=4, auto_en=0, pause=0 → clr=0001 for one cycle, then en=0001 on cycles 4, 8, 12 after S_RUN entry; mode stays 0.
- Single btn_next pulse in mode 3 → mode=0 one cycle later, clr=0001 for one cycle, led=00 that cycle, next en=0001 TICK_DIV cycles later.
- auto_en=1, AUTO_STEPS=3, TICK_DIV=4 → exactly 3 en pulses per mode, mode sequence 0,1,2,3,0; each mode change preceded by its third en and followed by one clr.
- Button edge on the same cycle as auto expiry in mode 1 → mode=2 (not 3); btn_next held high 20 cycles → one advance only.
- pause=1 for 10 cycles mid-count → no en, prescaler frozen; on release the remaining count completes before the next en; btn press during pause still advances mode.
- Reset asserted asynchronously between clock edges while en=0100 → en=0000, mode=0, led=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_mode_sequencer
//  Purpose  : Step-rate prescaler, mode selection and strobe generation for
//             the four LED pattern engines. Only the selected engine gets
//             clear/step strobes; its pattern is registered onto the LEDs.
//  Revision : 1.0  initial release
// ============================================================================
module led_mode_sequencer #(
  parameter int TICK_DIV   = 4,   // clock cycles per pattern step (>= 2)
  parameter int AUTO_STEPS = 16   // steps per mode before auto-advance (>= 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       pause,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  input  logic [7:0] pat3,
  output logic [1:0] mode,
  output logic [3:0] clr,
  output logic [3:0] en,
  output logic [7:0] led
);

  // Counter widths; a single-state counter still needs one bit to exist.
  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;

  localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] C_STEP_MAX  = SW'(AUTO_STEPS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t        state_q,    state_d;
  logic [1:0]    mode_q,     mode_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [SW-1:0] step_q,     step_d;
  logic          btn_prev_q, btn_prev_d;
  logic [7:0]    led_q,      led_d;

  logic [3:0]    mode_onehot;
  logic [7:0]    pat_sel;
  logic          tick;
  logic          btn_rise;
  logic          auto_expire;
  logic          advance;

  // Selected-engine decode and the event terms that drive sequencing.
  always_comb begin
    mode_onehot = 4'b0001 << mode_q;
    case (mode_q)
      2'd0:    pat_sel = pat0;
      2'd1:    pat_sel = pat1;
      2'd2:    pat_sel = pat2;
      default: pat_sel = pat3;
    endcase
    tick        = (state_q == S_RUN) && !pause && (presc_q == C_PRESC_MAX);
    btn_rise    = btn_next && !btn_prev_q;
    auto_expire = auto_en && tick && (step_q == C_STEP_MAX);
    // Button edge and auto expiry in the same cycle collapse into one advance.
    advance     = (state_q == S_RUN) && (btn_rise || auto_expire);
  end

  // Next-state computation for mode, counters and the LED register.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    step_d     = step_q;
    btn_prev_d = btn_next;
    led_d      = 8'h00;

    if (state_q == S_CLEAR) begin
      // One-cycle clear; button edges seen here are dropped on purpose.
      state_d = S_RUN;
      presc_d = '0;
      step_d  = '0;
      // The next cycle is S_RUN, so the LEDs start showing the new engine.
      led_d   = pat_sel;
    end else if (advance) begin
      mode_d  = mode_q + 2'd1;
      state_d = S_CLEAR;
      presc_d = '0;
      step_d  = '0;
      // LEDs are blanked for exactly the cycle the new engine is cleared.
      led_d   = 8'h00;
    end else begin
      led_d = pat_sel;
      if (!pause) begin
        presc_d = (presc_q == C_PRESC_MAX) ? '0 : presc_q + PW'(1);
      end
      // Step counter runs even with auto_en low; it only matters when set.
      if (tick) begin
        step_d = (step_q == C_STEP_MAX) ? '0 : step_q + SW'(1);
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      mode_q     <= 2'd0;
      presc_q    <= '0;
      step_q     <= '0;
      btn_prev_q <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      btn_prev_q <= btn_prev_d;
      led_q      <= led_d;
    end
  end

  // Strobes decode straight from registered state so reset kills them at once.
  always_comb begin
    clr = (state_q == S_CLEAR) ? mode_onehot : 4'b0000;
    en  = tick ? mode_onehot : 4'b0000;
  end

  assign mode = mode_q;
  assign led  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_mode_sequencer
//  Purpose  : Self-checking bench for led_mode_sequencer (TICK_DIV=4,
//             AUTO_STEPS=3) with a cycle-level reference model feeding a
//             scoreboard, plus scenario tasks with targeted checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int TD = 4;
  localparam int AS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] pat0 = 8'h00, pat1 = 8'h00, pat2 = 8'h00, pat3 = 8'h00;
  logic [1:0] mode;
  logic [3:0] clr;
  logic [3:0] en;
  logic [7:0] led;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] clr;
    logic [3:0] en;
    logic [7:0] led;
  } exp_t;

  exp_t sb[$];

  // Reference model state (0 = clearing, 1 = running)
  int         m_state = 0;
  int         m_mode  = 0;
  int         m_presc = 0;
  int         m_step  = 0;
  logic       m_bprev = 1'b0;
  logic [7:0] m_led   = 8'h00;
  bit         expiry_btn = 1'b0;

  led_mode_sequencer #(.TICK_DIV(TD), .AUTO_STEPS(AS)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .auto_en(auto_en),
    .pause(pause), .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
    .mode(mode), .clr(clr), .en(en), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat_of(input int m);
    case (m)
      0:       return pat0;
      1:       return pat1;
      2:       return pat2;
      default: return pat3;
    endcase
  endfunction

  function automatic bit model_tick();
    return (m_state == 1) && !pause && (m_presc == TD - 1);
  endfunction

  function automatic bit model_adv();
    return (m_state == 1) &&
           ((btn_next && !m_bprev) || (auto_en && model_tick() && m_step == AS - 1));
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.mode = 2'(m_mode);
    e.clr  = (m_state == 0) ? (4'b0001 << m_mode) : 4'b0000;
    e.en   = model_tick() ? (4'b0001 << m_mode) : 4'b0000;
    e.led  = m_led;
    return e;
  endfunction

  // Reference model: advances one cycle per clock, resets asynchronously.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_mode <= 0; m_presc <= 0; m_step <= 0;
      m_bprev <= 1'b0; m_led <= 8'h00;
    end else begin
      m_bprev <= btn_next;
      if (m_state == 0) begin
        m_state <= 1; m_presc <= 0; m_step <= 0;
        m_led   <= pat_of(m_mode);
      end else if (model_adv()) begin
        m_led   <= 8'h00;
        m_mode  <= (m_mode + 1) % 4;
        m_state <= 0; m_presc <= 0; m_step <= 0;
      end else begin
        m_led <= pat_of(m_mode);
        if (!pause) m_presc <= (m_presc + 1) % TD;
        if (model_tick()) m_step <= (m_step + 1) % AS;
      end
    end
  end

  // Scoreboard consumer: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({mode, clr, en, led} !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t mode=%0d want %0d clr=%b want %b en=%b want %b led=%h want %h",
                 $time, mode, e.mode, clr, e.clr, en, e.en, led, e.led);
      end
    end
  end

  // One clock of stimulus; the expectation is queued once inputs settle.
  task automatic drive(input logic b, input logic a, input logic p, input logic r);
    @(posedge clk);
    #1;
    reset    = r;
    btn_next = b;
    auto_en  = a;
    pause    = p;
    if (expiry_btn && m_state == 1 && m_mode == 1 && m_presc == TD - 1 &&
        m_step == AS - 1 && a && !p)
      btn_next = 1'b1;
    pat0 = 8'($urandom); pat1 = 8'($urandom);
    pat2 = 8'($urandom); pat3 = 8'($urandom);
    #1;
    sb.push_back(predict());
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    total++; if (clr !== 4'b0001) begin bad++; $display("FAIL reset_clr got %b want 0001", clr); end
    total++; if (en !== 4'b0000) begin bad++; $display("FAIL reset_en got %b want 0000", en); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got %0d want 0", mode); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got %h want 00", led); end
    // Release: this cycle is still the clearing cycle.
    drive(0, 0, 0, 0);
    total++; if (clr !== 4'b0001) begin bad++; $display("FAIL release_clr got %b want 0001", clr); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 13; i++) begin
      drive(0, 0, 0, 0);
      total++;
      if (en !== ((i % TD == 0) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL free_run_en cycle=%0d got %b want %b", i, en, (i % TD == 0) ? 4'b0001 : 4'b0000);
      end
      total++;
      if (mode !== 2'd0 || clr !== 4'b0000) begin
        bad++; $display("FAIL free_run_mode cycle=%0d got mode=%0d clr=%b want 0 0000", i, mode, clr);
      end
    end
  endtask

  task automatic test_button();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL button_to3 got %0d want 3", mode); end
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL button_wrap got %0d want 0", mode); end
    total++; if (clr !== 4'b0001) begin bad++; $display("FAIL button_clr got %b want 0001", clr); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL button_led got %h want 00", led); end
    for (int j = 1; j <= TD; j++) begin
      drive(0, 0, 0, 0);
      total++;
      if (en !== ((j == TD) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL button_first_en j=%0d got %b want %b", j, en, (j == TD) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_auto();
    int pulses = 0;
    int changes = 0;
    int prev_mode;
    int cyc = 0;
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    prev_mode = 0;
    while (changes < 4 && cyc < 200) begin
      drive(0, 1, 0, 0);
      cyc++;
      if (en !== 4'b0000) pulses++;
      if (clr !== 4'b0000) begin
        total++;
        if (pulses != AS || mode !== 2'((prev_mode + 1) % 4)) begin
          bad++; $display("FAIL auto_mode_change pulses=%0d want %0d mode=%0d want %0d",
                          pulses, AS, mode, (prev_mode + 1) % 4);
        end
        prev_mode = int'(mode);
        pulses = 0;
        changes++;
      end
    end
    total++;
    if (changes != 4) begin bad++; $display("FAIL auto_timeout changes=%0d want 4", changes); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int advances = 0;
    expiry_btn = 1'b1;
    while (btn_next !== 1'b1 && cyc < 100) begin
      drive(0, 1, 0, 0);
      cyc++;
    end
    expiry_btn = 1'b0;
    total++;
    if (btn_next !== 1'b1 || en !== 4'b0010) begin
      bad++; $display("FAIL simul_setup btn=%b en=%b want 1 0010", btn_next, en);
    end
    drive(0, 0, 0, 0);
    total++;
    if (mode !== 2'd2 || clr !== 4'b0100) begin
      bad++; $display("FAIL simul_single_advance mode=%0d clr=%b want 2 0100", mode, clr);
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0);
      if (clr !== 4'b0000) advances++;
    end
    drive(0, 0, 0, 0);
    total++;
    if (advances != 1 || mode !== 2'd3) begin
      bad++; $display("FAIL held_button advances=%0d mode=%0d want 1 3", advances, mode);
    end
  endtask

  task automatic test_pause();
    int cyc = 0;
    while (en === 4'b0000 && cyc < 20) begin
      drive(0, 0, 0, 0);
      cyc++;
    end
    total++; if (en !== 4'b1000) begin bad++; $display("FAIL pause_setup en=%b want 1000", en); end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0);
      total++; if (en !== 4'b0000) begin bad++; $display("FAIL pause_no_en i=%0d got %b want 0000", i, en); end
    end
    drive(0, 0, 0, 0);
    total++; if (en !== 4'b0000) begin bad++; $display("FAIL pause_resume1 got %b want 0000", en); end
    drive(0, 0, 0, 0);
    total++; if (en !== 4'b1000) begin bad++; $display("FAIL pause_resume2 got %b want 1000", en); end
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    total++;
    if (mode !== 2'd0 || clr !== 4'b0001) begin
      bad++; $display("FAIL pause_button mode=%0d clr=%b want 0 0001", mode, clr);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      total++;
      if (en !== 4'b0000 || clr !== 4'b0000) begin
        bad++; $display("FAIL pause_wait en=%b clr=%b want 0000 0000", en, clr);
      end
    end
    for (int j = 1; j <= TD; j++) begin
      drive(0, 0, 0, 0);
      total++;
      if (en !== ((j == TD) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL pause_release j=%0d got %b want %b", j, en, (j == TD) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    while (en !== 4'b0100 && cyc < 20) begin
      drive(0, 0, 0, 0);
      cyc++;
    end
    total++; if (en !== 4'b0100) begin bad++; $display("FAIL async_setup en=%b want 0100", en); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (en !== 4'b0000) begin bad++; $display("FAIL async_en got %b want 0000", en); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL async_mode got %0d want 0", mode); end
    total++; if (led !== 8'h00) begin bad++; $display("FAIL async_led got %h want 00", led); end
    void'(sb.pop_back());
    sb.push_back(predict());
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_button();
    test_auto();
    test_back_to_back();
    test_pause();
    test_async_reset();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
